// File: rtl/regfile_loader_pkg.sv
// regfile_loader_pkg: shared widths, the OPS register address, the loader
// state encoding and the header clamp that turns a count byte into N.
package regfile_loader_pkg;

    localparam int W = 8;
    localparam int D = 4;

    // Address of the OPS pointer register (r13).
    localparam logic [D-1:0] OPS_ADDR = 4'd13;

    // Number of registers in the file, held in the D+1 bit counter width.
    localparam logic [D:0] MAX_COUNT = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_DATA   = 3'd2,
        ST_OPS_HI = 3'd3,
        ST_OPS_LO = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    // A zero header or one larger than the register file means "load everything".
    function automatic logic [D:0] clamp_count(input logic [W-1:0] hdr);
        logic [D:0] n;
        if (hdr == '0 || hdr > {3'b000, MAX_COUNT}) begin
            n = MAX_COUNT;
        end else begin
            n = hdr[D:0];
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_loader_wr_stage.sv
// loader_wr_stage: the single registered stage in front of the register file
// write port. Strobes are one-cycle pulses; address and data hold between writes.
module loader_wr_stage
    import regfile_loader_pkg::*;
(
    input  logic         Clk,
    input  logic         ResetN,
    input  logic         wr_req,
    input  logic         ops_req,
    input  logic         ops_high,
    input  logic [D-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    output logic         WrEn,
    output logic [D-1:0] Waddr,
    output logic [W-1:0] DataIn,
    output logic         opsWrite,
    output logic         loadHigh
);

    logic         wr_en_q, wr_en_d;
    logic [D-1:0] waddr_q, waddr_d;
    logic [W-1:0] data_q, data_d;
    logic         ops_write_q, ops_write_d;
    logic         load_high_q, load_high_d;

    // Strobes fall back to 0 every cycle; address/data only move when a write is requested.
    always_comb begin
        wr_en_d     = 1'b0;
        ops_write_d = 1'b0;
        load_high_d = 1'b0;
        waddr_d     = waddr_q;
        data_d      = data_q;
        if (wr_req) begin
            wr_en_d = 1'b1;
            waddr_d = wr_addr;
            data_d  = wr_data;
        end else if (ops_req) begin
            ops_write_d = 1'b1;
            load_high_d = ops_high;
            data_d      = wr_data;
        end
    end

    // Output register with synchronous active-low clear.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            wr_en_q     <= 1'b0;
            waddr_q     <= '0;
            data_q      <= '0;
            ops_write_q <= 1'b0;
            load_high_q <= 1'b0;
        end else begin
            wr_en_q     <= wr_en_d;
            waddr_q     <= waddr_d;
            data_q      <= data_d;
            ops_write_q <= ops_write_d;
            load_high_q <= load_high_d;
        end
    end

    assign WrEn     = wr_en_q;
    assign Waddr    = waddr_q;
    assign DataIn   = data_q;
    assign opsWrite = ops_write_q;
    assign loadHigh = load_high_q;

endmodule

// File: rtl/regfile_loader.sv
// regfile_loader: bulk register-file preset from a valid/ready byte stream
// (count header followed by data bytes written at ascending addresses).
// Optional feature macro REGFILE_LOADER_OPS_SPLIT_EN: when defined, the byte
// for the OPS register is written high nibble first through opsWrite/loadHigh
// instead of the general WrEn port.
module regfile_loader
    import regfile_loader_pkg::*;
(
    input  logic         Clk,
    input  logic         ResetN,
    input  logic         Start,
    input  logic         InValid,
    input  logic [W-1:0] InData,
    output logic         InReady,
    output logic         WrEn,
    output logic [D-1:0] Waddr,
    output logic [W-1:0] DataIn,
    output logic         opsWrite,
    output logic         loadHigh,
    output logic         Busy,
    output logic         Done
);

    state_t       state_q, state_d;
    logic [D:0]   cnt_q, cnt_d;
    logic [D:0]   count_q, count_d;
    logic         done_q, done_d;

    logic         accept;
    logic         last_byte;
    logic         ops_hit;
    logic         wr_req;
    logic         ops_req;
    logic         ops_high;
    logic [W-1:0] wr_data;

`ifdef REGFILE_LOADER_OPS_SPLIT_EN
    logic [W-1:0] ops_byte_q, ops_byte_d;
    assign ops_hit = (cnt_q == {1'b0, OPS_ADDR});
`else
    assign ops_hit = 1'b0;
`endif

    assign accept    = InValid && InReady;
    assign last_byte = (cnt_q == count_q - 1'b1);

    // State, address counter, load length and the registered Done pulse.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
`ifdef REGFILE_LOADER_OPS_SPLIT_EN
            ops_byte_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            count_q    <= count_d;
            done_q     <= done_d;
`ifdef REGFILE_LOADER_OPS_SPLIT_EN
            ops_byte_q <= ops_byte_d;
`endif
        end
    end

    // Next-state and counter logic: header sets N, each data byte advances the address.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        count_d    = count_q;
        done_d     = 1'b0;
`ifdef REGFILE_LOADER_OPS_SPLIT_EN
        ops_byte_d = ops_byte_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    count_d = clamp_count(InData);
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    if (ops_hit) begin
`ifdef REGFILE_LOADER_OPS_SPLIT_EN
                        ops_byte_d = InData;
                        state_d    = ST_OPS_HI;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (last_byte) begin
                            state_d = ST_FIN;
                        end
                    end
                end
            end
`ifdef REGFILE_LOADER_OPS_SPLIT_EN
            ST_OPS_HI: begin
                state_d = ST_OPS_LO;
            end
            ST_OPS_LO: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = last_byte ? ST_FIN : ST_DATA;
            end
`endif
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake, status and write requests handed to the registered write stage.
    always_comb begin
        InReady  = (state_q == ST_HDR) || (state_q == ST_DATA);
        Busy     = (state_q != ST_IDLE) || done_q;
        wr_req   = 1'b0;
        ops_req  = 1'b0;
        ops_high = 1'b0;
        wr_data  = InData;
        if (state_q == ST_DATA && accept) begin
            if (ops_hit) begin
                ops_req  = 1'b1;
                ops_high = 1'b1;
                wr_data  = {4'h0, InData[7:4]};
            end else begin
                wr_req = 1'b1;
            end
        end
`ifdef REGFILE_LOADER_OPS_SPLIT_EN
        if (state_q == ST_OPS_HI) begin
            ops_req  = 1'b1;
            ops_high = 1'b0;
            wr_data  = {4'h0, ops_byte_q[3:0]};
        end
`endif
    end

    assign Done = done_q;

    loader_wr_stage u_wr_stage (
        .Clk      (Clk),
        .ResetN   (ResetN),
        .wr_req   (wr_req),
        .ops_req  (ops_req),
        .ops_high (ops_high),
        .wr_addr  (cnt_q[D-1:0]),
        .wr_data  (wr_data),
        .WrEn     (WrEn),
        .Waddr    (Waddr),
        .DataIn   (DataIn),
        .opsWrite (opsWrite),
        .loadHigh (loadHigh)
    );

endmodule

// File: tb/tb_regfile_loader.sv
// tb_regfile_loader: table-driven and randomized loads against a write-list
// model of the loader, plus cycle-exact sequences for the timing corner cases.
module tb_regfile_loader;

`ifdef REGFILE_LOADER_OPS_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       ResetN = 1'b0;
    logic       Start = 1'b0;
    logic       InValid = 1'b0;
    logic [7:0] InData = 8'h00;
    logic       InReady;
    logic       WrEn;
    logic [3:0] Waddr;
    logic [7:0] DataIn;
    logic       opsWrite;
    logic       loadHigh;
    logic       Busy;
    logic       Done;

    // kind: 0 = WrEn write, 1 = OPS high nibble, 2 = OPS low nibble
    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] addr;
        logic [7:0] data;
    } event_t;

    typedef struct {
        logic [7:0] hdr;
        int         gap_pct;
        bit         start_mid;
        int         exp_wr;
        int         exp_ops;
    } vec_t;

    event_t got_q[$];
    event_t exp_q[$];
    int     done_cnt = 0;
    bit     log_en = 1'b0;
    int     n_checks = 0;
    int     n_fails = 0;

    regfile_loader dut (
        .Clk      (Clk),
        .ResetN   (ResetN),
        .Start    (Start),
        .InValid  (InValid),
        .InData   (InData),
        .InReady  (InReady),
        .WrEn     (WrEn),
        .Waddr    (Waddr),
        .DataIn   (DataIn),
        .opsWrite (opsWrite),
        .loadHigh (loadHigh),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Number of data bytes a header announces.
    function automatic int clampN(input logic [7:0] h);
        return (h == 8'd0 || h > 8'd16) ? 16 : int'(h);
    endfunction

    // Record every strobe seen on the write port and check the standing invariants.
    always @(negedge Clk) begin
        if (log_en) begin
            if (WrEn) got_q.push_back({2'd0, Waddr, DataIn});
            if (opsWrite) got_q.push_back({(loadHigh ? 2'd1 : 2'd2), 4'd0, DataIn});
            if (Done) done_cnt++;
            checkOutput("strobe_exclusive", {31'd0, WrEn & opsWrite}, 32'd0);
            if (SPLIT && WrEn) checkOutput("no_wren_at_ops", {31'd0, Waddr == 4'd13}, 32'd0);
            if (opsWrite) checkOutput("ops_inready_low", {31'd0, InReady}, 32'd0);
        end
    end

    // Drive one complete load (header + exactly N bytes) and compare the strobes to the model.
    task automatic applyStimulus(input logic [7:0] hdr, input int gap_pct, input bit start_mid,
                                 input bit rand_data, output int n_wr, output int n_ops);
        logic [7:0] data_q[$];
        logic [7:0] items[$];
        int n;
        int idx;
        int cyc;
        n = clampN(hdr);
        for (int i = 0; i < n; i++) begin
            if (rand_data) data_q.push_back(8'($urandom));
            else data_q.push_back((i == 13) ? 8'h5C : 8'(i * 17 + 3));
        end
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            if (SPLIT && i == 13) begin
                exp_q.push_back({2'd1, 4'd0, 4'h0, data_q[i][7:4]});
                exp_q.push_back({2'd2, 4'd0, 4'h0, data_q[i][3:0]});
            end else begin
                exp_q.push_back({2'd0, 4'(i), data_q[i]});
            end
        end
        items.push_back(hdr);
        foreach (data_q[i]) items.push_back(data_q[i]);
        got_q.delete();
        done_cnt = 0;
        log_en = 1'b1;
        Start = 1'b1;
        step();
        Start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < items.size() && cyc < 2000) begin
            InValid = (gap_pct == 0) || ($urandom_range(0, 99) >= gap_pct);
            InData = InValid ? items[idx] : 8'($urandom);
            Start = start_mid && (idx == 3);
            @(negedge Clk);
            if (InValid && InReady) idx++;
            step();
            cyc++;
        end
        InValid = 1'b0;
        Start = 1'b0;
        checkOutput("stream_accepted", idx, items.size());
        cyc = 0;
        while (done_cnt == 0 && cyc < 40) begin
            step();
            cyc++;
        end
        step();
        step();
        log_en = 1'b0;
        checkOutput("event_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            checkOutput($sformatf("event_%0d", i), {18'd0, got_q[i]}, {18'd0, exp_q[i]});
        checkOutput("done_pulses", done_cnt, 1);
        n_wr = 0;
        n_ops = 0;
        foreach (got_q[i]) begin
            if (got_q[i].kind == 2'd0) n_wr++;
            else n_ops++;
        end
    endtask

    initial begin
        vec_t vecs[8];
        int n_wr;
        int n_ops;
        int seen_wr;
        int seen_done;

        vecs[0] = '{8'd3,  0,  1'b0, 3,                  0};
        vecs[1] = '{8'h20, 0,  1'b1, (SPLIT ? 15 : 16), (SPLIT ? 2 : 0)};
        vecs[2] = '{8'd0,  0,  1'b0, (SPLIT ? 15 : 16), (SPLIT ? 2 : 0)};
        vecs[3] = '{8'd1,  40, 1'b0, 1,                  0};
        vecs[4] = '{8'd13, 30, 1'b0, 13,                 0};
        vecs[5] = '{8'd14, 25, 1'b1, (SPLIT ? 13 : 14), (SPLIT ? 2 : 0)};
        vecs[6] = '{8'd17, 50, 1'b0, (SPLIT ? 15 : 16), (SPLIT ? 2 : 0)};
        vecs[7] = '{8'd16, 0,  1'b0, (SPLIT ? 15 : 16), (SPLIT ? 2 : 0)};

        // Reset held for two edges: everything quiet.
        ResetN = 1'b0;
        step();
        step();
        @(negedge Clk);
        checkOutput("rst_wren", {31'd0, WrEn}, 0);
        checkOutput("rst_waddr", {28'd0, Waddr}, 0);
        checkOutput("rst_datain", {24'd0, DataIn}, 0);
        checkOutput("rst_opswrite", {31'd0, opsWrite}, 0);
        checkOutput("rst_loadhigh", {31'd0, loadHigh}, 0);
        checkOutput("rst_inready", {31'd0, InReady}, 0);
        checkOutput("rst_busy", {31'd0, Busy}, 0);
        checkOutput("rst_done", {31'd0, Done}, 0);
        @(posedge Clk);
        #1 ResetN = 1'b1;
        step();

        // Basic load, cycle exact.
        Start = 1'b1;
        step();
        Start = 1'b0;
        InValid = 1'b1;
        InData = 8'd3;
        @(negedge Clk);
        checkOutput("basic_hdr_inready", {31'd0, InReady}, 1);
        checkOutput("basic_busy", {31'd0, Busy}, 1);
        step();
        InData = 8'hA1;
        step();
        InData = 8'hB2;
        @(negedge Clk);
        checkOutput("basic_w0", {19'd0, WrEn, Waddr, DataIn}, {19'd0, 1'b1, 4'd0, 8'hA1});
        step();
        InData = 8'hC3;
        @(negedge Clk);
        checkOutput("basic_w1", {19'd0, WrEn, Waddr, DataIn}, {19'd0, 1'b1, 4'd1, 8'hB2});
        step();
        InValid = 1'b0;
        @(negedge Clk);
        checkOutput("basic_w2", {19'd0, WrEn, Waddr, DataIn}, {19'd0, 1'b1, 4'd2, 8'hC3});
        checkOutput("basic_no_early_done", {31'd0, Done}, 0);
        step();
        @(negedge Clk);
        checkOutput("basic_done", {30'd0, Done, WrEn}, {30'd0, 1'b1, 1'b0});
        checkOutput("basic_busy_with_done", {31'd0, Busy}, 1);
        step();
        @(negedge Clk);
        checkOutput("basic_done_clear", {30'd0, Done, Busy}, 0);
        step();

        // Bubbles: header 2, InValid 1,0,0,1 on the data bytes.
        Start = 1'b1;
        step();
        Start = 1'b0;
        InValid = 1'b1;
        InData = 8'd2;
        step();
        InData = 8'h11;
        step();
        InValid = 1'b0;
        @(negedge Clk);
        checkOutput("bub_w0", {19'd0, WrEn, Waddr, DataIn}, {19'd0, 1'b1, 4'd0, 8'h11});
        step();
        @(negedge Clk);
        checkOutput("bub_gap1", {31'd0, WrEn}, 0);
        step();
        InValid = 1'b1;
        InData = 8'h22;
        @(negedge Clk);
        checkOutput("bub_gap2", {31'd0, WrEn}, 0);
        step();
        InValid = 1'b0;
        @(negedge Clk);
        checkOutput("bub_w1", {19'd0, WrEn, Waddr, DataIn}, {19'd0, 1'b1, 4'd1, 8'h22});
        step();
        @(negedge Clk);
        checkOutput("bub_done", {30'd0, Done, WrEn}, {30'd0, 1'b1, 1'b0});
        step();
        step();

        // Mid-load reset after the second accepted byte of a 5-byte load.
        Start = 1'b1;
        step();
        Start = 1'b0;
        InValid = 1'b1;
        InData = 8'd5;
        step();
        InData = 8'h31;
        step();
        InData = 8'h32;
        step();
        ResetN = 1'b0;
        InData = 8'h33;
        step();
        ResetN = 1'b1;
        @(negedge Clk);
        checkOutput("mrst_idle", {29'd0, Busy, InReady, WrEn}, 0);
        checkOutput("mrst_outputs", {20'd0, Waddr, DataIn}, 0);
        seen_wr = 0;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge Clk);
            if (WrEn) seen_wr++;
            if (Done) seen_done++;
        end
        checkOutput("mrst_no_writes", seen_wr, 0);
        checkOutput("mrst_no_done", seen_done, 0);
        InValid = 1'b0;
        step();
        applyStimulus(8'd2, 0, 1'b0, 1'b0, n_wr, n_ops);
        checkOutput("mrst_reload_writes", n_wr, 2);

        // Table of whole loads.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].hdr, vecs[i].gap_pct, vecs[i].start_mid, 1'b0, n_wr, n_ops);
            checkOutput($sformatf("vec%0d_wr", i), n_wr, vecs[i].exp_wr);
            checkOutput($sformatf("vec%0d_ops", i), n_ops, vecs[i].exp_ops);
            step();
        end

        // Randomized loads against the model.
        for (int r = 0; r < 8; r++) begin
            applyStimulus(8'($urandom_range(0, 40)), int'($urandom_range(0, 60)),
                          1'($urandom_range(0, 1)), 1'b1, n_wr, n_ops);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/regfile_loader.md
# regfile_loader

Sequential bulk loader that drives the register file's write port from a byte stream. It is used at boot and by the test harness to preset all registers, including the OPS pointer register (r13), before the core starts issuing instructions. It accepts a valid/ready byte stream consisting of a count header followed by data bytes. It then issues one register write per data byte at ascending addresses and pulses Done when the load completes.

## Interface
- W, 8, data path width (fixed)
- D, 4, register address width; the register file holds 2**D registers
- OPS_ADDR, 13, address of the OPS pointer register
- Clk  in  1  clock; all state updates on posedge
- ResetN  in  1  synchronous, active-low reset
- Start  in  1  single-cycle request to begin a load; honoured only in IDLE
- InValid  in  1  InData holds a byte
- InData  in  W  stream byte
- InReady  out  1  loader can accept a byte this cycle
- WrEn  out  1  general register write strobe
- Waddr  out  D  write address
- DataIn  out  W  write data
- opsWrite  out  1  OPS nibble write strobe
- loadHigh  out  1  with opsWrite: 1 writes OPS[7:4], 0 writes OPS[3:0]
- Busy  out  1  state is not IDLE
- Done  out  1  one-cycle pulse at load completion

## Operation
- States: IDLE, HDR, DATA, OPS_HI, OPS_LO, FIN.
- A byte is accepted when InValid && InReady. InReady is 1 only in HDR and DATA.
- IDLE + Start -> HDR. Start in any other state is ignored.
- HDR: the accepted byte h sets the count N. N = 2**D when h==0 or h>2**D; otherwise N = h. Then -> DATA with address counter a=0. The counter is D+1 bits wide.
- DATA: for an accepted byte b at address a, the loader registers WrEn=1, Waddr=a and DataIn=b, then increments a.
  - If a==N-1, the next state is FIN.
  - If OPS split is enabled and a==OPS_ADDR, the byte is diverted to OPS_HI instead of being written directly (see Configuration).
- OPS_HI: drives opsWrite=1, loadHigh=1, DataIn={4'h0,b[7:4]} -> OPS_LO.
- OPS_LO: drives opsWrite=1, loadHigh=0, DataIn={4'h0,b[3:0]}. Then -> FIN if a==N-1, otherwise -> DATA.
- FIN: Done=1 for one cycle -> IDLE.
- Strobe exclusivity: WrEn and opsWrite are never both 1 in the same cycle.
- Gaps in InValid produce no strobes. All strobes default to 0 and Waddr/DataIn hold their last value.
- Reset (ResetN=0 at a clock edge) from any state:
  - state -> IDLE; all outputs 0; counter 0.
  - No Done is issued and no further writes occur for the aborted load.

## Timing
- Start at edge k -> HDR at k+1; InReady=1 from k+1.
- Byte accepted at edge t -> WrEn/Waddr/DataIn valid during the cycle after t (one registered stage).
- Sustained throughput is 1 byte/cycle except around OPS:
  - split path: InReady=0 for the two OPS cycles
  - write order: OPS[7:4] is written on the cycle after acceptance, OPS[3:0] on the cycle after that
- Done is asserted the cycle after the last write strobe. Busy falls together with Done's deassertion.
- Minimum total latency for N bytes with no gaps: 1 (Start) + 1 (hdr) + N (+2 if OPS split) + 1 (Done) cycles.

## Configuration
- REGFILE_LOADER_OPS_SPLIT_EN
  - Defined: the byte destined for OPS_ADDR is written only through the two-cycle opsWrite nibble path, high nibble first. WrEn is never asserted with Waddr==OPS_ADDR.
  - Undefined: OPS_HI and OPS_LO are not synthesised, opsWrite and loadHigh are tied 0, and address OPS_ADDR is written with WrEn like any other register.

## Structure
- Package regfile_loader_pkg holds:
  - the state enum (3-bit encoding)
  - OPS_ADDR
  - the header-clamp helper function computing N
- One sub-module is natural: loader_wr_stage, the output register stage that owns WrEn, opsWrite, loadHigh, Waddr and DataIn and their reset values. The FSM and counter stay in the top module.

## Test plan
- Reset: hold ResetN=0 for 2 cycles -> all outputs 0, InReady=0, Busy=0.
- Basic load: Start, header 3, bytes 0xA1,0xB2,0xC3 with InValid constant -> WrEn at (0,0xA1),(1,0xB2),(2,0xC3) on consecutive cycles, then Done pulses once on the following cycle.
- OPS split (macro defined): header 0, 16 bytes with byte 13 = 0x5C -> opsWrite/loadHigh=1/DataIn=0x05, then opsWrite/loadHigh=0/DataIn=0x0C, InReady=0 for those 2 cycles, then WrEn at address 14. With the macro undefined, the same stimulus gives WrEn at (13,0x5C).
- Bubbles: header 2, InValid toggling 1,0,0,1 -> exactly two WrEn pulses, at addresses 0 and 1, and none during gaps.
- Clamp/ignore: header 0x20 -> 16 writes. A Start pulse mid-DATA changes nothing.
- Mid-load reset: ResetN=0 after the 2nd accepted byte of a 5-byte load -> IDLE next cycle, no further WrEn, no Done. A new Start then loads from address 0.
